butterfly_r2_tw: RTL and testbench
==================================

Name: butterfly_r2_tw

Overview:
- Pipelined radix-2 complex butterfly for the FFT datapath; generalised successor of the real-valued sum/difference-with-1/sqrt2 stage.
- Computes X = A + B and Y = (A − B)·W, with W selected per sample from {1, −j, W8^1, W8^3}.
- Signed two's-complement data, valid-qualified, fully pipelined: one sample per cycle, fixed 3-cycle latency.
- Sits between the FFT input reorder buffer and the next butterfly column.

Parameters:
- N, 3, data width is W = 2**N bits per real component (N=3 gives 8 bits).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  reset: asynchronous, active-high
- in_valid  input  1  input sample valid
- mode  input  2  twiddle select: 0 = 1, 1 = −j, 2 = W8^1 = (1−j)/sqrt2, 3 = W8^3 = (−1−j)/sqrt2
- a_re, a_im, b_re, b_im  input  W each  signed operands
- out_valid  output  1  result valid
- x_re, x_im  output  W each  A + B
- y_re, y_im  output  W each  twiddled difference

Behaviour:
- Reset: asynchronous, active-high. All pipeline registers, out_valid and all data outputs are forced to 0 immediately and held at 0 while rst = 1.
- Reset mid-stream: in-flight samples are discarded. No out_valid pulse may appear for a sample accepted before rst asserted.
- Valid pipeline: v1 <= in_valid, v2 <= v1, out_valid <= v2.
- Latency: out_valid rises exactly 3 clk edges after the edge that samples in_valid = 1.
- Throughput: back-to-back inputs are accepted every cycle. There is no backpressure.
- Data registers in each stage load only when that stage's incoming valid is 1; otherwise they hold. Outputs therefore hold their last value while out_valid = 0.
- Stage 1:
  - s = A + B and d = A − B, computed at W+1 bits (sign-extended).
  - Register s, d and mode.
- Stage 2, twiddle on d, all at W+2 bits:
  - mode 0: p = (d_re, d_im)
  - mode 1: p = (d_im, −d_re)
  - mode 2: p = (d_re + d_im, d_im − d_re), flagged for scaling
  - mode 3: p = (d_im − d_re, −(d_re + d_im)), flagged for scaling
  - s is delayed alongside.
- Stage 3, scaling and width reduction:
  - Flagged components: q = (p·181) >>> 8, arithmetic shift, i.e. floor. 181/256 approximates 1/sqrt2.
  - Unflagged components: q = p.
  - Reduce q and s to W bits by two's-complement wrap (default), or by saturation under SAT_EN.
  - Register the results as y and x.
- Overflow cases that must be handled: A+B exceeding W bits; negation of −2^(W−1) in mode 1.

Optional Feature:
- Macro: BUTTERFLY_SAT_EN.
- Defined: every final W-bit reduction saturates to [−2^(W−1), 2^(W−1)−1].
- Undefined: every final W-bit reduction keeps the low W bits (wrap). Latency is identical in both builds.

Decomposition:
- Package butterfly_pkg holds:
  - twiddle constants TW_ONE = 2'd0, TW_NEG_J = 2'd1, TW_W8_1 = 2'd2, TW_W8_3 = 2'd3
  - INV_SQRT2_K = 181 and INV_SQRT2_SH = 8
  - a function for the W-bit reduction (wrap or saturate, macro-controlled)
- One sub-module: inv_sqrt2_scale.
  - Registered, one cycle.
  - Inputs: W+2-bit value, scale flag, valid.
  - Output: W bits after the multiply, shift and reduction.
  - Instantiated twice in stage 3, once for re and once for im.

Test Plan (N = 3, W = 8):
- Mode 0: A = (10, 20), B = (3, 5), in_valid pulsed once -> 3 cycles later out_valid = 1 for exactly one cycle, X = (13, 25), Y = (7, 15).
- Same A and B, back-to-back with mode 1, then 2, then 3 on consecutive cycles -> out_valid high for 3 consecutive cycles:
  - mode 1: Y = (15, −7)
  - mode 2: Y = (15, 5)
  - mode 3: Y = (5, −16), checking floor on negatives
  - X = (13, 25) for each.
- Overflow: A = (100, 0), B = (100, 0), mode 0 -> x_re = −56 (wrap build) or 127 (BUTTERFLY_SAT_EN build).
- Mode 1 with A = (0, 0), B = (0, 0), then A = (−128, 0), B = (0, 0):
  - second sample d_re = −128, so y_im = +128 before reduction
  - expect y_im = −128 (wrap) or 127 (sat), with y_re = 0.
- Reset mid-stream: 2 valid samples in flight, assert rst asynchronously between clk edges -> outputs and out_valid go to 0 immediately. After release with in_valid = 0, out_valid stays 0 for 5 cycles.
- Idle hold: one valid sample followed by in_valid = 0 for 10 cycles -> x/y hold the last result and out_valid = 0 after its single pulse.

Source files
------------

// File: rtl/butterfly_pkg.sv
// Shared constants and the final W-bit reduction for the radix-2 twiddle butterfly.
// Defining BUTTERFLY_SAT_EN makes every reduction saturate instead of wrap.
package butterfly_pkg;

    localparam logic [1:0] TW_ONE   = 2'd0;
    localparam logic [1:0] TW_NEG_J = 2'd1;
    localparam logic [1:0] TW_W8_1  = 2'd2;
    localparam logic [1:0] TW_W8_3  = 2'd3;

    localparam int INV_SQRT2_K  = 181;
    localparam int INV_SQRT2_SH = 8;

    // Result is sign-extended to 32 bits; callers keep the low i_w bits.
    function automatic logic signed [31:0] reduce_w(input logic signed [31:0] i_v, input int i_w);
`ifdef BUTTERFLY_SAT_EN
        logic signed [31:0] r_hi;
        logic signed [31:0] r_lo;
        r_hi = (32'sd1 <<< (i_w - 1)) - 32'sd1;
        r_lo = -(32'sd1 <<< (i_w - 1));
        if (i_v > r_hi)
            return r_hi;
        else if (i_v < r_lo)
            return r_lo;
        else
            return i_v;
`else
        return (i_v <<< (32 - i_w)) >>> (32 - i_w);
`endif
    endfunction

endpackage

// File: rtl/butterfly_r2_tw_inv_sqrt2_scale.sv
// One-cycle registered 1/sqrt2 scaler (181/256, floor) with final W-bit reduction.
// Reduction mode follows BUTTERFLY_SAT_EN through butterfly_pkg::reduce_w.
module inv_sqrt2_scale
    import butterfly_pkg::*;
#(
    parameter int W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_valid,
    input  logic                i_scale,
    input  logic signed [W+1:0] i_val,
    output logic signed [W-1:0] o_q
);

    logic signed [31:0] w_ext;
    logic signed [31:0] w_prod;
    logic signed [31:0] w_q;

    assign w_ext  = 32'(i_val);
    assign w_prod = w_ext * INV_SQRT2_K;
    assign w_q    = i_scale ? (w_prod >>> INV_SQRT2_SH) : w_ext;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            o_q <= '0;
        else if (i_valid)
            o_q <= W'(reduce_w(w_q, W));
    end

endmodule

// File: rtl/butterfly_r2_tw.sv
// Three-stage radix-2 butterfly: X = A + B, Y = (A - B) * W with W from {1, -j, W8^1, W8^3}.
// Build with BUTTERFLY_SAT_EN to saturate the final W-bit outputs instead of wrapping.
module butterfly_r2_tw
    import butterfly_pkg::*;
#(
    parameter int N = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic [1:0]                 mode,
    input  logic signed [(2**N)-1:0]   a_re,
    input  logic signed [(2**N)-1:0]   a_im,
    input  logic signed [(2**N)-1:0]   b_re,
    input  logic signed [(2**N)-1:0]   b_im,
    output logic                       out_valid,
    output logic signed [(2**N)-1:0]   x_re,
    output logic signed [(2**N)-1:0]   x_im,
    output logic signed [(2**N)-1:0]   y_re,
    output logic signed [(2**N)-1:0]   y_im
);

    localparam int W  = 2**N;
    localparam int WS = W + 1;
    localparam int WP = W + 2;

    logic                  r_v1;
    logic                  r_v2;
    logic [1:0]            r_mode1;
    logic signed [WS-1:0]  r_s1_re;
    logic signed [WS-1:0]  r_s1_im;
    logic signed [WS-1:0]  r_d_re;
    logic signed [WS-1:0]  r_d_im;
    logic signed [WS-1:0]  r_s2_re;
    logic signed [WS-1:0]  r_s2_im;
    logic signed [WP-1:0]  r_p_re;
    logic signed [WP-1:0]  r_p_im;
    logic                  r_scale2;

    logic signed [WS-1:0]  w_s_re;
    logic signed [WS-1:0]  w_s_im;
    logic signed [WS-1:0]  w_d_re;
    logic signed [WS-1:0]  w_d_im;
    logic signed [WP-1:0]  w_dr;
    logic signed [WP-1:0]  w_di;
    logic signed [WP-1:0]  w_p_re;
    logic signed [WP-1:0]  w_p_im;
    logic                  w_scale;

    assign w_s_re = WS'(a_re) + WS'(b_re);
    assign w_s_im = WS'(a_im) + WS'(b_im);
    assign w_d_re = WS'(a_re) - WS'(b_re);
    assign w_d_im = WS'(a_im) - WS'(b_im);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v1    <= 1'b0;
            r_mode1 <= '0;
            r_s1_re <= '0;
            r_s1_im <= '0;
            r_d_re  <= '0;
            r_d_im  <= '0;
        end else begin
            r_v1 <= in_valid;
            if (in_valid) begin
                r_mode1 <= mode;
                r_s1_re <= w_s_re;
                r_s1_im <= w_s_im;
                r_d_re  <= w_d_re;
                r_d_im  <= w_d_im;
            end
        end
    end

    // W+2 bits leave room for d_re + d_im and for negating the most negative d.
    always_comb begin
        w_dr    = WP'(r_d_re);
        w_di    = WP'(r_d_im);
        w_p_re  = w_dr;
        w_p_im  = w_di;
        w_scale = 1'b0;
        case (r_mode1)
            TW_ONE: begin
                w_p_re = w_dr;
                w_p_im = w_di;
            end
            TW_NEG_J: begin
                w_p_re = w_di;
                w_p_im = -w_dr;
            end
            TW_W8_1: begin
                w_p_re  = w_dr + w_di;
                w_p_im  = w_di - w_dr;
                w_scale = 1'b1;
            end
            TW_W8_3: begin
                w_p_re  = w_di - w_dr;
                w_p_im  = -(w_dr + w_di);
                w_scale = 1'b1;
            end
            default: begin
                w_p_re = w_dr;
                w_p_im = w_di;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v2     <= 1'b0;
            r_p_re   <= '0;
            r_p_im   <= '0;
            r_scale2 <= 1'b0;
            r_s2_re  <= '0;
            r_s2_im  <= '0;
        end else begin
            r_v2 <= r_v1;
            if (r_v1) begin
                r_p_re   <= w_p_re;
                r_p_im   <= w_p_im;
                r_scale2 <= w_scale;
                r_s2_re  <= r_s1_re;
                r_s2_im  <= r_s1_im;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            x_re      <= '0;
            x_im      <= '0;
        end else begin
            out_valid <= r_v2;
            if (r_v2) begin
                x_re <= W'(reduce_w(32'(r_s2_re), W));
                x_im <= W'(reduce_w(32'(r_s2_im), W));
            end
        end
    end

    inv_sqrt2_scale #(.W(W)) u_scale_re (
        .clk     (clk),
        .rst     (rst),
        .i_valid (r_v2),
        .i_scale (r_scale2),
        .i_val   (r_p_re),
        .o_q     (y_re)
    );

    inv_sqrt2_scale #(.W(W)) u_scale_im (
        .clk     (clk),
        .rst     (rst),
        .i_valid (r_v2),
        .i_scale (r_scale2),
        .i_val   (r_p_im),
        .o_q     (y_im)
    );

endmodule

// File: tb/tb_butterfly_r2_tw.sv
// Directed and random bench for butterfly_r2_tw with a latency-tagged scoreboard.
// Expected values track BUTTERFLY_SAT_EN when the bundle is built with it.
module tb_butterfly_r2_tw;

    localparam int N = 3;
    localparam int W = 8;

    logic                clk = 1'b0;
    logic                rst;
    logic                in_valid;
    logic [1:0]          mode;
    logic signed [W-1:0] a_re, a_im, b_re, b_im;
    logic                out_valid;
    logic signed [W-1:0] x_re, x_im, y_re, y_im;

    butterfly_r2_tw #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .mode      (mode),
        .a_re      (a_re),
        .a_im      (a_im),
        .b_re      (b_re),
        .b_im      (b_im),
        .out_valid (out_valid),
        .x_re      (x_re),
        .x_im      (x_im),
        .y_re      (y_re),
        .y_im      (y_im)
    );

    always #5 clk = ~clk;

    typedef struct {
        int x_re;
        int x_im;
        int y_re;
        int y_im;
        int due;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    exp_t last_exp;

    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input int obs, input int expv);
        checks++;
        assert (obs === expv)
        else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    function automatic int red(input int v);
        int m;
`ifdef BUTTERFLY_SAT_EN
        if (v > 127) return 127;
        if (v < -128) return -128;
        return v;
`else
        m = v & 255;
        if (m > 127) m = m - 256;
        return m;
`endif
    endfunction

    function automatic int sc(input int p);
        return $rtoi($floor(real'(p) * 181.0 / 256.0));
    endfunction

    function automatic exp_t model(input int ar, input int ai, input int br, input int bi, input int md);
        exp_t e;
        int dr, di, pr, pi;
        bit f;
        dr = ar - br;
        di = ai - bi;
        f  = 1'b0;
        case (md)
            0: begin pr = dr; pi = di; end
            1: begin pr = di; pi = -dr; end
            2: begin pr = dr + di; pi = di - dr; f = 1'b1; end
            default: begin pr = di - dr; pi = -(dr + di); f = 1'b1; end
        endcase
        e.x_re = red(ar + br);
        e.x_im = red(ai + bi);
        e.y_re = red(f ? sc(pr) : pr);
        e.y_im = red(f ? sc(pi) : pi);
        e.due  = 0;
        return e;
    endfunction

    task automatic send(input int ar, input int ai, input int br, input int bi, input int md,
                        input int exr, input int exi, input int eyr, input int eyi);
        exp_t e;
        @(negedge clk);
        a_re     = W'(ar);
        a_im     = W'(ai);
        b_re     = W'(br);
        b_im     = W'(bi);
        mode     = 2'(md);
        in_valid = 1'b1;
        e.x_re = exr;
        e.x_im = exi;
        e.y_re = eyr;
        e.y_im = eyi;
        e.due  = cyc + 3;
        sb.push_back(e);
        last_exp = e;
    endtask

    task automatic send_m(input int ar, input int ai, input int br, input int bi, input int md);
        exp_t e;
        e = model(ar, ai, br, bi, md);
        send(ar, ai, br, bi, md, e.x_re, e.x_im, e.y_re, e.y_im);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_out_valid"}, int'(out_valid), 0);
        chk({tag, "_x_re"}, int'(x_re), 0);
        chk({tag, "_x_im"}, int'(x_im), 0);
        chk({tag, "_y_re"}, int'(y_re), 0);
        chk({tag, "_y_im"}, int'(y_im), 0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst === 1'b0 && out_valid === 1'b1) begin
            checks++;
            assert (sb.size() > 0)
            else begin
                errors++;
                $error("FAIL spurious_out_valid observed pulse at cycle %0d expected none", cyc);
            end
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("latency", cyc, e.due);
                chk("x_re", int'(x_re), e.x_re);
                chk("x_im", int'(x_im), e.x_im);
                chk("y_re", int'(y_re), e.y_re);
                chk("y_im", int'(y_im), e.y_im);
            end
        end
    end

    initial begin
        int xov, yov;
        rst      = 1'b1;
        in_valid = 1'b0;
        mode     = 2'd0;
        a_re = '0; a_im = '0; b_re = '0; b_im = '0;
        #12;
        chk_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        // Test plan: mode 0 single pulse, then modes 1..3 back to back.
        send(10, 20, 3, 5, 0, 13, 25, 7, 15);
        idle(6);
        send(10, 20, 3, 5, 1, 13, 25, 15, -7);
        send(10, 20, 3, 5, 2, 13, 25, 15, 5);
        send(10, 20, 3, 5, 3, 13, 25, 5, -16);
        idle(6);

`ifdef BUTTERFLY_SAT_EN
        xov = 127;
        yov = 127;
`else
        xov = -56;
        yov = -128;
`endif
        send(100, 0, 100, 0, 0, xov, 0, 0, 0);
        send(0, 0, 0, 0, 1, 0, 0, 0, 0);
        send(-128, 0, 0, 0, 1, -128, 0, 0, yov);
        idle(6);

        for (int i = 0; i < 24; i++) begin
            send_m(int'($urandom_range(255)) - 128, int'($urandom_range(255)) - 128,
                   int'($urandom_range(255)) - 128, int'($urandom_range(255)) - 128,
                   int'($urandom_range(3)));
            if ($urandom_range(3) == 0) idle(int'($urandom_range(2)) + 1);
        end
        idle(6);

        // Reset with two samples in flight.
        send_m(50, -60, 70, 80, 2);
        send_m(-90, 33, 44, -12, 3);
        idle(1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk_zero("async_rst");
        sb.delete();
        @(negedge clk);
        chk_zero("rst_held");
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("post_rst_out_valid", int'(out_valid), 0);
        end

        // Idle hold after a single result.
        send_m(7, -3, -20, 9, 2);
        idle(10);
        chk("hold_out_valid", int'(out_valid), 0);
        chk("hold_x_re", int'(x_re), last_exp.x_re);
        chk("hold_x_im", int'(x_im), last_exp.x_im);
        chk("hold_y_re", int'(y_re), last_exp.y_re);
        chk("hold_y_im", int'(y_im), last_exp.y_im);

        chk("scoreboard_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
